qdec_input_filter: RTL and testbench
====================================

// Module: qdec_input_filter
// PURPOSE
//   Front end for the quadrature pulse counter. Synchronises raw PLUS_A/PLUS_B pins into
//   sys_clock, rejects glitches shorter than a programmable length, and decodes clean
//   transitions into one-cycle step/dir events plus illegal-transition errors. The
//   downstream counter adds or subtracts one per step; software programs filt_len over APB.
// PARAMETERS
//   SYNC_STAGES  2  synchroniser flops per pin (>=2)
//   FILT_BITS    8  width of filt_len and per-channel stability counters
//   ERR_BITS     8  width of saturating illegal-transition counter
// PORTS
//   sys_clock  in   1          sole clock
//   reset      in   1          synchronous, active-high
//   enable     in   1          0 = hold idle, re-acquire on rise
//   filt_len   in   FILT_BITS  extra stable cycles required before accepting a pin level
//   err_clr    in   1          one-cycle pulse, clears err_cnt
//   PLUS_A     in   1          raw encoder A (asynchronous)
//   PLUS_B     in   1          raw encoder B (asynchronous)
//   a_filt     out  1          filtered A
//   b_filt     out  1          filtered B
//   locked     out  1          1 = initial levels acquired, decoding active
//   step       out  1          one-cycle pulse per legal transition
//   dir        out  1          1 = forward (+1), 0 = reverse; valid with step, holds otherwise
//   quad_err   out  1          one-cycle pulse: A and B changed in same cycle
//   err_cnt    out  ERR_BITS   saturating count of quad_err pulses
// BEHAVIOUR
//   - Reset (or enable=0): sync flops, a_filt, b_filt, stability counters, step, quad_err,
//     locked, dir all 0; err_cnt 0 on reset only (kept while enable=0). FSM -> ACQ.
//   - Synchroniser: SYNC_STAGES flops per pin; s_a/s_b = last stage.
//   - Glitch filter per channel (f = filtered, s = synced, cnt): if s==f: cnt<=0.
//     Else if cnt==filt_len: f<=s, cnt<=0. Else cnt<=cnt+1. Any return of s to f before
//     acceptance restarts cnt. filt_len=0 accepts on first differing cycle.
//   - Latency pin->a_filt/b_filt = SYNC_STAGES+1+filt_len cycles; pulses shorter than
//     filt_len+1 synced cycles never reach the output.
//   - filt_len changed mid-count: new value compared immediately; if cnt already > new
//     filt_len, cnt keeps counting to wrap (no acceptance until equality) -- software
//     changes filt_len only while enable=0.
//   - FSM ACQ: filters load f<=s after s stable filt_len+1 cycles per channel, no step
//     emitted; when both channels stable-loaded -> RUN, locked<=1 next cycle.
//   - FSM RUN: compare registered prev {a,b} with current {a_filt,b_filt}:
//     forward sequence 00->10->11->01->00 (AB): step=1, dir=1;
//     reverse (opposite order): step=1, dir=0; no change: step=0;
//     both bits changed: quad_err=1, step=0, dir unchanged.
//   - step/quad_err registered: asserted the cycle after the filtered edge, exactly one cycle.
//   - err_cnt: +1 per quad_err, saturates at all-ones; err_clr wins over simultaneous
//     quad_err (result 0).
//   - enable falling mid-operation: outputs cleared next cycle, no step on re-entry;
//     re-acquire via ACQ on rise.
// STRUCTURE
//   - qdec_defs.vh: FSM encodings (QDEC_ACQ, QDEC_RUN), DIR_FWD/DIR_REV, forward-transition
//     table as localparams.
//   - Sub-module qdec_glitch_filter (synchroniser + stability counter, one channel),
//     instantiated twice; decoder, FSM and err_cnt in the top.
// TESTING
//   - Reset, filt_len=3, A=B=0 held 10 cycles -> locked=1, no step, err_cnt=0.
//   - Forward cycle AB 00,10,11,01,00 each held 20 cycles -> 4 step pulses, dir=1,
//     each 7 cycles after pin edge.
//   - Reverse cycle 00,01,11,10,00 -> 4 steps, dir=0; dir holds 0 afterwards.
//   - filt_len=3: 3-cycle A pulse -> no a_filt change, no step; 4-cycle pulse -> accepted.
//   - A and B toggled same edge (00->11) -> quad_err once, no step, err_cnt=1;
//     255+5 repeats -> err_cnt=255; err_clr with quad_err same cycle -> err_cnt=0.
//   - enable=0 mid-sequence with A=1 -> step/locked 0 next cycle; enable=1 -> ACQ,
//     locked after filt_len+1 stable cycles, no spurious step.

Source files
------------

// File: rtl/qdec_input_filter_pkg.sv
// rtl/qdec_input_filter_pkg.sv - shared FSM encoding, direction codes and quadrature transition table
package qdec_input_filter_pkg;

    typedef enum logic {
        QDEC_ACQ = 1'b0,
        QDEC_RUN = 1'b1
    } qdec_state_e;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Forward successor of each {A,B} state, indexed by 2*AB:
    // 00->10, 01->00, 10->11, 11->01
    localparam logic [7:0] FWD_NEXT_TABLE = 8'b01_11_00_10;

    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        return FWD_NEXT_TABLE[{ab, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/qdec_glitch_filter.sv
// rtl/qdec_glitch_filter.sv - one-channel pin synchroniser with stability-count glitch filter
module qdec_glitch_filter
    import qdec_input_filter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_BITS   = 8
) (
    input  logic                 clk_i,
    input  logic                 clr_i,
    input  logic                 pin_i,
    input  logic [FILT_BITS-1:0] filt_len_i,
    output logic                 filt_o,
    output logic                 loaded_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    // Valid marker travelling alongside the pin so the cleared chain contents are never acquired
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   lvl_q, lvl_d;
    logic                   f_q, f_d;
    logic                   loaded_q, loaded_d;
    logic [FILT_BITS-1:0]   cnt_q, cnt_d;

    logic s;
    logic s_next;
    logic s_valid;

    assign s       = sync_q[SYNC_STAGES-1];
    assign s_next  = sync_q[SYNC_STAGES-2];
    assign s_valid = prime_q[SYNC_STAGES-1];

    // Acquisition waits for a stable level to load; afterwards changes must persist filt_len+1 cycles
    always_comb begin
        f_d      = f_q;
        cnt_d    = cnt_q;
        lvl_d    = lvl_q;
        loaded_d = loaded_q;
        if (!loaded_q) begin
            if (!s_valid) begin
                lvl_d = s_next;
                cnt_d = '0;
            end else if (s != lvl_q) begin
                lvl_d = s;
                cnt_d = '0;
            end else if (cnt_q == filt_len_i) begin
                f_d      = s;
                loaded_d = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + FILT_BITS'(1);
            end
        end else begin
            if (s == f_q) begin
                cnt_d = '0;
            end else if (cnt_q == filt_len_i) begin
                f_d   = s;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + FILT_BITS'(1);
            end
        end
    end

    // Synchroniser chain and filter state; clear covers both reset and disable
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sync_q   <= '0;
            prime_q  <= '0;
            lvl_q    <= 1'b0;
            f_q      <= 1'b0;
            loaded_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prime_q  <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            lvl_q    <= lvl_d;
            f_q      <= f_d;
            loaded_q <= loaded_d;
            cnt_q    <= cnt_d;
        end
    end

    assign filt_o   = f_q;
    assign loaded_o = loaded_q;

endmodule

// File: rtl/qdec_input_filter.sv
// rtl/qdec_input_filter.sv - quadrature front end: filtered pins, step/dir decode, error counter
module qdec_input_filter
    import qdec_input_filter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_BITS   = 8,
    parameter int ERR_BITS    = 8
) (
    input  logic                 sys_clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [FILT_BITS-1:0] filt_len,
    input  logic                 err_clr,
    input  logic                 PLUS_A,
    input  logic                 PLUS_B,
    output logic                 a_filt,
    output logic                 b_filt,
    output logic                 locked,
    output logic                 step,
    output logic                 dir,
    output logic                 quad_err,
    output logic [ERR_BITS-1:0]  err_cnt
);

    logic clr;
    logic a_loaded;
    logic b_loaded;
    logic [1:0] cur_ab;

    qdec_state_e         state_q, state_d;
    logic [1:0]          prev_q;
    logic                step_q, step_d;
    logic                dir_q, dir_d;
    logic                quad_err_q, quad_err_d;
    logic                locked_q;
    logic [ERR_BITS-1:0] err_cnt_q, err_cnt_d;

    assign clr    = reset | ~enable;
    assign cur_ab = {a_filt, b_filt};

    qdec_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_BITS  (FILT_BITS)
    ) u_filt_a (
        .clk_i     (sys_clock),
        .clr_i     (clr),
        .pin_i     (PLUS_A),
        .filt_len_i(filt_len),
        .filt_o    (a_filt),
        .loaded_o  (a_loaded)
    );

    qdec_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_BITS  (FILT_BITS)
    ) u_filt_b (
        .clk_i     (sys_clock),
        .clr_i     (clr),
        .pin_i     (PLUS_B),
        .filt_o    (b_filt),
        .filt_len_i(filt_len),
        .loaded_o  (b_loaded)
    );

    // Next state and decode: acquire both levels silently, then classify each filtered change
    always_comb begin
        state_d    = state_q;
        step_d     = 1'b0;
        quad_err_d = 1'b0;
        dir_d      = dir_q;
        case (state_q)
            QDEC_ACQ: begin
                if (a_loaded && b_loaded) begin
                    state_d = QDEC_RUN;
                end
            end
            QDEC_RUN: begin
                if (cur_ab != prev_q) begin
                    if (cur_ab == fwd_next(prev_q)) begin
                        step_d = 1'b1;
                        dir_d  = DIR_FWD;
                    end else if (prev_q == fwd_next(cur_ab)) begin
                        step_d = 1'b1;
                        dir_d  = DIR_REV;
                    end else begin
                        quad_err_d = 1'b1;
                    end
                end
            end
            default: state_d = QDEC_ACQ;
        endcase
    end

    // Error counter: clear beats a coinciding error pulse, otherwise saturate at all-ones
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (quad_err_q && (err_cnt_q != {ERR_BITS{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_BITS'(1);
        end
    end

    // FSM, previous-level register and registered event outputs; disable behaves like reset here
    always_ff @(posedge sys_clock) begin
        if (clr) begin
            state_q    <= QDEC_ACQ;
            prev_q     <= 2'b00;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            quad_err_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= cur_ab;
            step_q     <= step_d;
            dir_q      <= dir_d;
            quad_err_q <= quad_err_d;
            locked_q   <= (state_q == QDEC_RUN);
        end
    end

    // Error count survives disable; only reset clears it
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked   = locked_q;
    assign step     = step_q;
    assign dir      = dir_q;
    assign quad_err = quad_err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_qdec_input_filter.sv
// tb/tb_qdec_input_filter.sv - scoreboard bench for the quadrature input filter
module tb_qdec_input_filter;

    logic       sys_clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] filt_len;
    logic       err_clr;
    logic       PLUS_A;
    logic       PLUS_B;
    logic       a_filt;
    logic       b_filt;
    logic       locked;
    logic       step;
    logic       dir;
    logic       quad_err;
    logic [7:0] err_cnt;

    typedef struct {
        bit is_err;
        bit dir;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  seen;

    localparam int LAT = 7;

    qdec_input_filter #(
        .SYNC_STAGES(2),
        .FILT_BITS  (8),
        .ERR_BITS   (8)
    ) dut (
        .sys_clock(sys_clock),
        .reset    (reset),
        .enable   (enable),
        .filt_len (filt_len),
        .err_clr  (err_clr),
        .PLUS_A   (PLUS_A),
        .PLUS_B   (PLUS_B),
        .a_filt   (a_filt),
        .b_filt   (b_filt),
        .locked   (locked),
        .step     (step),
        .dir      (dir),
        .quad_err (quad_err),
        .err_cnt  (err_cnt)
    );

    always #5 sys_clock = ~sys_clock;

    always @(posedge sys_clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clock);
    endtask

    task automatic expect_ev(input bit is_err, input bit d, input int lat);
        ev_t e;
        e.is_err = is_err;
        e.dir    = d;
        e.cyc    = cyc + lat;
        exp_q.push_back(e);
    endtask

    // Monitor: every step/quad_err pulse must match the oldest expected event
    always @(negedge sys_clock) begin
        if (!reset && (step || quad_err)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: step=%0b quad_err=%0b at cycle %0d, expected none",
                         step, quad_err, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("ev_quad_err", 32'(quad_err), 32'(mon_e.is_err));
                check("ev_step", 32'(step), 32'(!mon_e.is_err));
                check("ev_dir", 32'(dir), 32'(mon_e.dir));
                check("ev_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        logic [1:0] fwd_seq [4];
        logic [1:0] rev_seq [4];
        fwd_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        rev_seq = '{2'b01, 2'b11, 2'b10, 2'b00};

        reset    = 1'b1;
        enable   = 1'b1;
        filt_len = 8'd3;
        err_clr  = 1'b0;
        PLUS_A   = 1'b0;
        PLUS_B   = 1'b0;
        tick(3);
        check("rst_a_filt", 32'(a_filt), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_step", 32'(step), 0);
        check("rst_dir", 32'(dir), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        reset = 1'b0;
        tick(10);
        check("acq_locked", 32'(locked), 1);
        check("acq_err_cnt", 32'(err_cnt), 0);

        for (int i = 0; i < 4; i++) begin
            {PLUS_A, PLUS_B} = fwd_seq[i];
            expect_ev(1'b0, 1'b1, LAT);
            tick(20);
        end
        check("fwd_dir", 32'(dir), 1);

        for (int i = 0; i < 4; i++) begin
            {PLUS_A, PLUS_B} = rev_seq[i];
            expect_ev(1'b0, 1'b0, LAT);
            tick(20);
        end
        check("rev_dir", 32'(dir), 0);
        tick(5);
        check("rev_dir_hold", 32'(dir), 0);

        seen   = 1'b0;
        PLUS_A = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) PLUS_A = 1'b0;
            tick(1);
            if (a_filt) seen = 1'b1;
        end
        check("glitch3_a_filt", 32'(seen), 0);

        PLUS_A = 1'b1;
        expect_ev(1'b0, 1'b1, LAT);
        expect_ev(1'b0, 1'b0, LAT + 4);
        tick(4);
        PLUS_A = 1'b0;
        tick(20);
        check("glitch4_a_filt", 32'(a_filt), 0);

        {PLUS_A, PLUS_B} = 2'b11;
        expect_ev(1'b1, 1'b0, LAT);
        tick(12);
        check("quad_err_cnt1", 32'(err_cnt), 1);
        {PLUS_A, PLUS_B} = 2'b00;
        expect_ev(1'b1, 1'b0, LAT);
        tick(8);
        for (int i = 0; i < 258; i++) begin
            {PLUS_A, PLUS_B} = (i % 2 == 0) ? 2'b11 : 2'b00;
            expect_ev(1'b1, 1'b0, LAT);
            tick(8);
        end
        tick(2);
        check("err_cnt_sat", 32'(err_cnt), 255);

        {PLUS_A, PLUS_B} = 2'b11;
        expect_ev(1'b1, 1'b0, LAT);
        tick(LAT);
        err_clr = 1'b1;
        check("clr_align_quad_err", 32'(quad_err), 1);
        tick(1);
        err_clr = 1'b0;
        check("clr_wins", 32'(err_cnt), 0);
        tick(3);
        check("clr_hold", 32'(err_cnt), 0);
        {PLUS_A, PLUS_B} = 2'b00;
        expect_ev(1'b1, 1'b0, LAT);
        tick(12);
        check("err_cnt_after_clr", 32'(err_cnt), 1);

        {PLUS_A, PLUS_B} = 2'b10;
        expect_ev(1'b0, 1'b1, LAT);
        tick(20);
        check("pre_dis_a_filt", 32'(a_filt), 1);
        enable = 1'b0;
        tick(1);
        check("dis_step", 32'(step), 0);
        check("dis_locked", 32'(locked), 0);
        check("dis_a_filt", 32'(a_filt), 0);
        check("dis_dir", 32'(dir), 0);
        check("dis_err_cnt_kept", 32'(err_cnt), 1);
        tick(5);
        enable = 1'b1;
        tick(3);
        check("reacq_not_locked", 32'(locked), 0);
        tick(7);
        check("reacq_locked", 32'(locked), 1);
        check("reacq_a_filt", 32'(a_filt), 1);
        {PLUS_A, PLUS_B} = 2'b11;
        expect_ev(1'b0, 1'b1, LAT);
        tick(20);

        check("events_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
